cram_port_arbiter: RTL

//  Shares one CRAM controller request port between NUM_REQ independent requesters
//  (e.g. bridge ROM loader writes and core fetch reads on cram0), one transaction at a time.

---
 rtl/cram_port_arbiter_if.sv | 31 +++
 rtl/cram_port_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cram_port_arbiter_if.sv
// Requester-side and controller-side signals of the shared CRAM port.
// slave = arbiter view, master = requesters/controller view.
interface cram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ack;
  logic [DATA_W-1:0]         req_rdata;
  logic                      mem_valid;
  logic                      mem_ready;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_done;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_done, mem_rdata,
    output req_ack, req_rdata, mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_done, mem_rdata,
    input  req_ack, req_rdata, mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cram_port_arbiter.sv
// One-at-a-time arbiter onto a single CRAM controller port; request-to-ack >= 3 cycles.
// Command held stable under mem_ready backpressure; losers simply hold req_valid.
module cram_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  cram_port_arbiter_if.slave         bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t            state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;

  logic              any_req;
  logic [ID_W-1:0]   winner;
  logic [ID_W:0]     scan_idx;

  // Scan starts at the RR pointer (or 0 in fixed mode); first set request wins.
  always_comb begin
    any_req  = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (FIXED_PRIO != 0) begin
        scan_idx = (ID_W+1)'(i);
      end else begin
        scan_idx = {1'b0, rr_q} + (ID_W+1)'(i);
        if (scan_idx >= (ID_W+1)'(NUM_REQ)) scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!any_req && bus.req_valid[scan_idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        winner  = scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          mem_valid_d = 1'b1;
          mem_we_d    = bus.req_we[winner];
          mem_addr_d  = bus.req_addr[winner*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.req_wdata[winner*DATA_W +: DATA_W];
          grant_d     = winner;
          if (FIXED_PRIO == 0)
            rr_d = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          if (bus.mem_done) begin
            if (!mem_we_q) rdata_d = bus.mem_rdata;
            state_d = RESP;
          end else begin
            state_d = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (bus.mem_done) begin
          if (!mem_we_q) rdata_d = bus.mem_rdata;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      grant_q     <= '0;
      rr_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
    end
  end

  always_comb begin
    bus.req_ack = '0;
    if (state_q == RESP) bus.req_ack[grant_q] = 1'b1;
  end

  assign bus.req_rdata = rdata_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;
endmodule
